port_b_arbiter: RTL and testbench

PORT_B_ARBITER -- requirements
Module: port_b_arbiter

---
 rtl/port_b_arbiter.sv | 130 +++++++++++++
 tb/tb_port_b_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_b_arbiter.sv
// Port B arbiter: shares one synchronous-read memory port between VGA reads and
// SNES button-state writes, with a starvation bound so pending writes always land.
module port_b_arbiter #(
   parameter int                    ADDR_WIDTH   = 12,
   parameter logic [ADDR_WIDTH-1:0] SNES_ADDR    = 12'hFFF,
   parameter int                    STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  vga_req,
   input  logic [ADDR_WIDTH-1:0] vga_addr,
   output logic                  vga_ack,
   output logic [15:0]           vga_data,
   input  logic                  snes_valid,
   input  logic [11:0]           button_data,
   output logic [ADDR_WIDTH-1:0] addr_b,
   output logic [15:0]           data_b,
   output logic                  w_en_b,
   input  logic [15:0]           mem_out_b,
   output logic                  pending
);

   localparam int             CW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0]  STARVE_MAX = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      VGA_RD  = 2'd1,
      VGA_CAP = 2'd2,
      SNES_WR = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [ADDR_WIDTH-1:0]   addr_next;
   logic [15:0]             data_next;
   logic                    wen_next;
   logic                    ack_next;
   logic [15:0]             vdata_next;
   logic                    pend_next;
   logic [11:0]             pend_data;
   logic [11:0]             pdata_next;
   logic [CW-1:0]           starve_cnt;
   logic [CW-1:0]           starve_next;
   logic                    starved;

   assign starved = pending && (starve_cnt == STARVE_MAX);

   // Next-state and next-output logic; every port-B output is registered.
   always_comb begin
      state_next  = state;
      addr_next   = addr_b;
      data_next   = data_b;
      wen_next    = 1'b0;
      ack_next    = 1'b0;
      vdata_next  = vga_data;
      pend_next   = pending;
      pdata_next  = pend_data;
      starve_next = starve_cnt;

      case (state)
         IDLE: begin
            if (vga_req && !starved) begin
               addr_next  = vga_addr;
               state_next = VGA_RD;
               if (pending && (starve_cnt != STARVE_MAX)) begin
                  starve_next = starve_cnt + CW'(1);
               end
            end else if (pending) begin
               addr_next  = SNES_ADDR;
               data_next  = {4'b0000, pend_data};
               wen_next   = 1'b1;
               state_next = SNES_WR;
            end
         end
         VGA_RD: begin
            state_next = VGA_CAP;
         end
         VGA_CAP: begin
            vdata_next = mem_out_b;
            ack_next   = 1'b1;
            state_next = IDLE;
         end
         SNES_WR: begin
            pend_next   = 1'b0;
            starve_next = '0;
            state_next  = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // A fresh button sample always wins, even over the write retiring now.
      if (snes_valid) begin
         pend_next  = 1'b1;
         pdata_next = button_data;
      end

      if (!pending) begin
         starve_next = '0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         addr_b     <= '0;
         data_b     <= '0;
         w_en_b     <= 1'b0;
         vga_ack    <= 1'b0;
         vga_data   <= '0;
         pending    <= 1'b0;
         pend_data  <= '0;
         starve_cnt <= '0;
      end else begin
         state      <= state_next;
         addr_b     <= addr_next;
         data_b     <= data_next;
         w_en_b     <= wen_next;
         vga_ack    <= ack_next;
         vga_data   <= vdata_next;
         pending    <= pend_next;
         pend_data  <= pdata_next;
         starve_cnt <= starve_next;
      end
   end

endmodule

// File: tb/tb_port_b_arbiter.sv
// Directed self-checking bench for port_b_arbiter with a 1-cycle synchronous
// memory model attached to port B.
module tb_port_b_arbiter;

   logic        clk;
   logic        reset;
   logic        vga_req;
   logic [11:0] vga_addr;
   logic        vga_ack;
   logic [15:0] vga_data;
   logic        snes_valid;
   logic [11:0] button_data;
   logic [11:0] addr_b;
   logic [15:0] data_b;
   logic        w_en_b;
   logic [15:0] mem_out_b;
   logic        pending;

   int vectors;
   int miscompares;

   logic [15:0] mem     [0:4095];
   bit          written [0:4095];

   port_b_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .vga_req     (vga_req),
      .vga_addr    (vga_addr),
      .vga_ack     (vga_ack),
      .vga_data    (vga_data),
      .snes_valid  (snes_valid),
      .button_data (button_data),
      .addr_b      (addr_b),
      .data_b      (data_b),
      .w_en_b      (w_en_b),
      .mem_out_b   (mem_out_b),
      .pending     (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] init_word(input logic [11:0] a);
      init_word = (a == 12'h010) ? 16'hBEEF : {4'h5, a};
   endfunction

   // Memory model: registered read of the address presented at the edge.
   always @(posedge clk) begin
      mem_out_b <= written[addr_b] ? mem[addr_b] : init_word(addr_b);
      if (w_en_b) begin
         mem[addr_b]     <= data_b;
         written[addr_b] <= 1'b1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      vectors++;
      if (vga_ack !== 1'b0 || w_en_b !== 1'b0 || pending !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: ack=%b wen=%b pend=%b required 0 0 0", vga_ack, w_en_b, pending);
      end
      vectors++;
      if (addr_b !== 12'h000 || data_b !== 16'h0000 || vga_data !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_data: addr=%h data=%h vdata=%h required 000 0000 0000", addr_b, data_b, vga_data);
      end
      step();
      reset = 1'b1;
   endtask

   task automatic test_single_read();
      vga_req  = 1'b1;
      vga_addr = 12'h010;
      step();
      vectors++;
      if (addr_b !== 12'h010 || vga_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL read_issue: addr=%h ack=%b required 010 0", addr_b, vga_ack);
      end
      step();
      vectors++;
      if (vga_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL read_early_ack: ack=%b required 0", vga_ack);
      end
      step();
      vectors++;
      if (vga_ack !== 1'b1 || vga_data !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL read_ack: ack=%b data=%h required 1 BEEF", vga_ack, vga_data);
      end
      vga_req = 1'b0;
      step();
      vectors++;
      if (vga_ack !== 1'b0 || vga_data !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL read_hold: ack=%b data=%h required 0 BEEF", vga_ack, vga_data);
      end
      step();
   endtask

   task automatic test_button_write();
      snes_valid  = 1'b1;
      button_data = 12'hA5C;
      step();
      snes_valid = 1'b0;
      vectors++;
      if (pending !== 1'b1 || w_en_b !== 1'b0) begin
         miscompares++;
         $display("FAIL btn_pending: pend=%b wen=%b required 1 0", pending, w_en_b);
      end
      step();
      vectors++;
      if (w_en_b !== 1'b1 || addr_b !== 12'hFFF || data_b !== 16'h0A5C) begin
         miscompares++;
         $display("FAIL btn_issue: wen=%b addr=%h data=%h required 1 FFF 0A5C", w_en_b, addr_b, data_b);
      end
      step();
      vectors++;
      if (w_en_b !== 1'b0 || pending !== 1'b0 || addr_b !== 12'hFFF || data_b !== 16'h0A5C) begin
         miscompares++;
         $display("FAIL btn_retire: wen=%b pend=%b addr=%h data=%h required 0 0 FFF 0A5C", w_en_b, pending, addr_b, data_b);
      end
      vectors++;
      if (mem[12'hFFF] !== 16'h0A5C) begin
         miscompares++;
         $display("FAIL btn_mem: mem=%h required 0A5C", mem[12'hFFF]);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [11:0] addrs [0:2];
      logic        exp_ack;
      addrs[0] = 12'h030;
      addrs[1] = 12'h031;
      addrs[2] = 12'h032;
      vga_req  = 1'b1;
      vga_addr = addrs[0];
      for (int k = 1; k <= 9; k++) begin
         step();
         exp_ack = (k % 3 == 0);
         vectors++;
         if (vga_ack !== exp_ack) begin
            miscompares++;
            $display("FAIL b2b_ack_%0d: ack=%b required %b", k, vga_ack, exp_ack);
         end
         if (exp_ack) begin
            vectors++;
            if (vga_data !== init_word(addrs[k/3-1])) begin
               miscompares++;
               $display("FAIL b2b_data_%0d: data=%h required %h", k, vga_data, init_word(addrs[k/3-1]));
            end
            if (k < 9) vga_addr = addrs[k/3];
            else       vga_req  = 1'b0;
         end
      end
      step();
   endtask

   task automatic test_overwrite();
      vga_req  = 1'b1;
      vga_addr = 12'h020;
      step();
      snes_valid  = 1'b1;
      button_data = 12'h001;
      step();
      button_data = 12'h002;
      step();
      snes_valid = 1'b0;
      vga_req    = 1'b0;
      vectors++;
      if (vga_ack !== 1'b1 || vga_data !== 16'h5020 || w_en_b !== 1'b0) begin
         miscompares++;
         $display("FAIL ovw_read: ack=%b data=%h wen=%b required 1 5020 0", vga_ack, vga_data, w_en_b);
      end
      step();
      vectors++;
      if (w_en_b !== 1'b1 || data_b !== 16'h0002 || addr_b !== 12'hFFF) begin
         miscompares++;
         $display("FAIL ovw_latest: wen=%b data=%h addr=%h required 1 0002 FFF", w_en_b, data_b, addr_b);
      end
      snes_valid  = 1'b1;
      button_data = 12'h003;
      step();
      snes_valid = 1'b0;
      vectors++;
      if (w_en_b !== 1'b0 || pending !== 1'b1 || data_b !== 16'h0002) begin
         miscompares++;
         $display("FAIL ovw_during_wr: wen=%b pend=%b data=%h required 0 1 0002", w_en_b, pending, data_b);
      end
      step();
      vectors++;
      if (w_en_b !== 1'b1 || data_b !== 16'h0003) begin
         miscompares++;
         $display("FAIL ovw_second: wen=%b data=%h required 1 0003", w_en_b, data_b);
      end
      step();
      vectors++;
      if (w_en_b !== 1'b0 || pending !== 1'b0 || mem[12'hFFF] !== 16'h0003) begin
         miscompares++;
         $display("FAIL ovw_done: wen=%b pend=%b mem=%h required 0 0 0003", w_en_b, pending, mem[12'hFFF]);
      end
      step();
   endtask

   task automatic test_starvation();
      bit found;
      bit wr;
      int acks;
      vga_req  = 1'b1;
      vga_addr = 12'h100;
      step();
      snes_valid  = 1'b1;
      button_data = 12'h3C3;
      step();
      snes_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (vga_ack) found = 1'b1;
         else         step();
      end
      vectors++;
      if (found !== 1'b1) begin
         miscompares++;
         $display("FAIL starve_inflight: seen=%b required 1", found);
      end
      acks = 0;
      wr   = 1'b0;
      for (int i = 0; i < 60 && !wr; i++) begin
         step();
         if (w_en_b)       wr = 1'b1;
         else if (vga_ack) acks++;
      end
      vectors++;
      if (wr !== 1'b1 || acks != 8) begin
         miscompares++;
         $display("FAIL starve_count: write=%b acks=%0d required 1 8", wr, acks);
      end
      vectors++;
      if (data_b !== 16'h03C3 || addr_b !== 12'hFFF || vga_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL starve_write: data=%h addr=%h ack=%b required 03C3 FFF 0", data_b, addr_b, vga_ack);
      end
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step();
         if (vga_ack) found = 1'b1;
      end
      vga_req = 1'b0;
      vectors++;
      if (found !== 1'b1 || vga_data !== 16'h5100 || pending !== 1'b0) begin
         miscompares++;
         $display("FAIL starve_resume: seen=%b data=%h pend=%b required 1 5100 0", found, vga_data, pending);
      end
      step();
   endtask

   task automatic test_reset_mid_read();
      vga_req  = 1'b1;
      vga_addr = 12'h010;
      step();
      snes_valid  = 1'b1;
      button_data = 12'h777;
      step();
      snes_valid = 1'b0;
      reset      = 1'b0;
      #1;
      vectors++;
      if (vga_ack !== 1'b0 || w_en_b !== 1'b0 || pending !== 1'b0 ||
          addr_b !== 12'h000 || data_b !== 16'h0000 || vga_data !== 16'h0000) begin
         miscompares++;
         $display("FAIL midrst_clear: ack=%b wen=%b pend=%b addr=%h data=%h vdata=%h required all 0",
                  vga_ack, w_en_b, pending, addr_b, data_b, vga_data);
      end
      step();
      vectors++;
      if (vga_ack !== 1'b0 || vga_data !== 16'h0000) begin
         miscompares++;
         $display("FAIL midrst_hold: ack=%b vdata=%h required 0 0000", vga_ack, vga_data);
      end
      reset = 1'b1;
      step();
      vectors++;
      if (addr_b !== 12'h010 || w_en_b !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_first: addr=%h wen=%b required 010 0", addr_b, w_en_b);
      end
      step();
      vectors++;
      if (vga_ack !== 1'b0 || w_en_b !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_wait: ack=%b wen=%b required 0 0", vga_ack, w_en_b);
      end
      step();
      vga_req = 1'b0;
      vectors++;
      if (vga_ack !== 1'b1 || vga_data !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL midrst_ack: ack=%b data=%h required 1 BEEF", vga_ack, vga_data);
      end
      step();
      vectors++;
      if (vga_ack !== 1'b0 || w_en_b !== 1'b0 || pending !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_lost: ack=%b wen=%b pend=%b required 0 0 0", vga_ack, w_en_b, pending);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      vga_req     = 1'b0;
      vga_addr    = '0;
      snes_valid  = 1'b0;
      button_data = '0;
      #2;
      test_reset();
      step();
      test_single_read();
      test_button_write();
      test_back_to_back();
      test_overwrite();
      test_starvation();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
